data_sram_responder: RTL and testbench
======================================

// Module: data_sram_responder
// PURPOSE
//   Responder end of the core's data SRAM interface (en/wen/addr/wdata -> rdata).
//   Decodes each access to one of three targets:
//   - an internal 64-bit-wide RAM;
//   - a CLINT register block (msip, mtimecmp, mtime);
//   - unmapped space.
//   Generates the MSI/MTI interrupt inputs that the top-level wrapper feeds into the core.
//   Used in simulation and FPGA builds in place of an external data memory.
// PARAMETERS
//   RAM_BASE   32'h8000_0000  byte base address of RAM window
//   RAM_AW     16             log2 of RAM depth in 64-bit words (RAM = 2^RAM_AW * 8 bytes)
//   CLINT_BASE 32'h0200_0000  byte base address of CLINT window (64 KiB)
//   TICK_DIV   1              clock cycles per mtime increment (>=1)
// PORTS
//   clock            in   1   single clock, all state on rising edge
//   reset            in   1   asynchronous, active-low reset
//   data_sram_en     in   1   access request this cycle
//   data_sram_wen    in   8   byte write enables; 0 = read
//   data_sram_addr   in   32  byte address; addr[2:0] ignored (dword aligned)
//   data_sram_wdata  in   64  write data, byte i on bits [8i+7:8i]
//   data_sram_rdata  out  64  read data, valid the cycle after a read request
//   MSI              out  1   machine software interrupt (msip[0])
//   MTI              out  1   machine timer interrupt (mtime >= mtimecmp)
//   bad_access       out  1   1-cycle pulse: previous-cycle access hit unmapped space
// BEHAVIOUR
//   Reset (reset==0, async):
//     - rdata=0, MSI=0, MTI=0, bad_access=0.
//     - msip=0, mtime=0, mtimecmp=64'hFFFF_FFFF_FFFF_FFFF, prescaler=0.
//     - RAM contents not reset.
//   Decode uses word address A = {addr[31:3],3'b000}:
//     - RAM when RAM_BASE <= A < RAM_BASE + 2^(RAM_AW+3); index = A[RAM_AW+2:3].
//     - CLINT offsets from CLINT_BASE: 0x0000 msip (bit0 only, rest read 0),
//       0x4000 mtimecmp, 0xBFF8 mtime. Other CLINT offsets read 0; writes to them are dropped.
//     - Everything else is unmapped.
//   Read (en=1, wen=0):
//     - rdata is updated on the next rising edge with the target value as sampled at request time.
//     - Latency is exactly 1 cycle.
//     - rdata holds its value until the next read. Writes and idle cycles do not change it.
//   Write (en=1, wen!=0):
//     - Only bytes with wen[i]=1 are updated. This applies to RAM and to CLINT registers.
//     - The write takes effect at the rising edge that ends the request cycle.
//     - No response and no stall. The responder always accepts one access per cycle.
//   Back-to-back read after a write to the same address returns the new data.
//   en=0: no state change except the timer.
//   Unmapped access (read or write): bad_access=1 in the next cycle. Read returns rdata=0. Write is dropped.
//   Timer:
//     - The prescaler counts 0..TICK_DIV-1. mtime += 1 (mod 2^64) on each prescaler wrap.
//     - With TICK_DIV=1, mtime increments every cycle.
//     - A CPU write to mtime in the same cycle as a tick wins; the tick is lost for that cycle.
//     - Partial-byte writes merge with the pre-tick value.
//   Interrupts:
//     - MTI is registered: MTI <= (mtime_next >= mtimecmp_next), unsigned 64-bit compare.
//       MTI therefore reflects the state after this edge's updates.
//     - MSI is the registered msip[0].
//     - Both are level outputs with no latching. Software clears them by writing mtimecmp or msip.
//   mtime wraps from all-ones to 0 without any flag.
//   Reset asserted mid-access: the access is abandoned and all registers return to reset values.
//     The RAM word being written may or may not be updated.
// TESTING
//   1. Reset release, then read A=0x8000_0000 -> rdata valid at cycle+1.
//      MTI=0, MSI=0, bad_access=0 throughout.
//   2. Write 64'h1122_3344_5566_7788 with wen=8'hFF to 0x8000_0010.
//      Then write wen=8'h0F, wdata=64'hAAAA_AAAA_BBBB_BBBB to the same address.
//      Then read it -> rdata=64'h1122_3344_BBBB_BBBB one cycle after the read.
//   3. Write mtime=100 and mtimecmp=105 (TICK_DIV=1) -> MTI rises exactly 5 cycles after
//      the mtime write edge. Then write mtimecmp=all-ones -> MTI=0 on the next cycle.
//   4. Write msip=1 (0x0200_0000, wen=8'h01) -> MSI=1 next cycle.
//      Read msip -> rdata=1. Write 0 -> MSI=0.
//   5. Read 0x1000_0000 -> rdata=0 and bad_access=1 for one cycle.
//      Write to 0x1000_0000 -> bad_access pulse; no RAM or CLINT state changes.
//   6. Drive reset=0 asynchronously mid-write with mtime=500 -> all outputs 0 immediately.
//      After release: mtime counts from 0 and mtimecmp reads all-ones.

Source files
------------

// File: rtl/data_sram_responder.sv
// Data SRAM responder: 64-bit RAM window, CLINT timer/soft-irq block,
// and unmapped-space detection with 1-cycle read latency.
module data_sram_responder #(
  parameter logic [31:0] RAM_BASE   = 32'h8000_0000,
  parameter int          RAM_AW     = 16,
  parameter logic [31:0] CLINT_BASE = 32'h0200_0000,
  parameter int          TICK_DIV   = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        data_sram_en,
  input  logic [7:0]  data_sram_wen,
  input  logic [31:0] data_sram_addr,
  input  logic [63:0] data_sram_wdata,
  output logic [63:0] data_sram_rdata,
  output logic        MSI,
  output logic        MTI,
  output logic        bad_access
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [32:0] RAM_LO = {1'b0, RAM_BASE};
  localparam logic [32:0] RAM_HI = RAM_LO + (33'd1 << (RAM_AW + 3));
  localparam logic [PW-1:0] PMAX = PW'(TICK_DIV - 1);

  localparam logic [15:0] OFF_MSIP  = 16'h0000;
  localparam logic [15:0] OFF_MTCMP = 16'h4000;
  localparam logic [15:0] OFF_MTIME = 16'hBFF8;

  logic [63:0] mem [2**RAM_AW];

  logic [63:0]     rdata_q, rdata_d;
  logic            msip_q, msip_d;
  logic [63:0]     mtime_q, mtime_d;
  logic [63:0]     mtcmp_q, mtcmp_d;
  logic [PW-1:0]   presc_q, presc_d;
  logic            mti_q, mti_d;
  logic            bad_q, bad_d;

  logic [31:0]       word_a;
  logic [15:0]       off;
  logic [RAM_AW-1:0] ram_idx;
  logic              ram_hit, clint_hit, unmapped;
  logic              is_rd, is_wr, ram_wr, tick;
  logic [63:0]       rd_val;
  logic              unused_addr_lsb;

  assign unused_addr_lsb = ^data_sram_addr[2:0];

  function automatic logic [63:0] merge(
    input logic [63:0] old,
    input logic [63:0] nw,
    input logic [7:0]  be
  );
    logic [63:0] r;
    r = old;
    for (int i = 0; i < 8; i++) begin
      if (be[i]) r[8*i +: 8] = nw[8*i +: 8];
    end
    return r;
  endfunction

  assign word_a    = {data_sram_addr[31:3], 3'b000};
  assign off       = word_a[15:0];
  assign ram_idx   = word_a[RAM_AW+2:3];
  assign ram_hit   = ({1'b0, word_a} >= RAM_LO) &&
                     ({1'b0, word_a} < RAM_HI);
  assign clint_hit = (word_a[31:16] == CLINT_BASE[31:16]);
  assign unmapped  = !ram_hit && !clint_hit;
  assign is_rd     = data_sram_en && (data_sram_wen == 8'h00);
  assign is_wr     = data_sram_en && (data_sram_wen != 8'h00);
  assign ram_wr    = is_wr && ram_hit;
  assign tick      = (presc_q == PMAX);

  always_comb begin
    rd_val = '0;
    unique case (1'b1)
      ram_hit:   rd_val = mem[ram_idx];
      clint_hit: begin
        if (off == OFF_MSIP)  rd_val = {63'd0, msip_q};
        if (off == OFF_MTCMP) rd_val = mtcmp_q;
        if (off == OFF_MTIME) rd_val = mtime_q;
      end
      unmapped:  rd_val = '0;
    endcase
  end

  always_comb begin
    rdata_d = rdata_q;
    msip_d  = msip_q;
    mtcmp_d = mtcmp_q;
    presc_d = tick ? '0 : presc_q + 1'b1;
    mtime_d = tick ? mtime_q + 64'd1 : mtime_q;
    bad_d   = data_sram_en && unmapped;
    if (is_rd) rdata_d = rd_val;
    // CPU writes merge against the pre-tick value and override the tick
    if (is_wr && clint_hit) begin
      if (off == OFF_MSIP && data_sram_wen[0])
        msip_d = data_sram_wdata[0];
      if (off == OFF_MTCMP)
        mtcmp_d = merge(mtcmp_q, data_sram_wdata, data_sram_wen);
      if (off == OFF_MTIME)
        mtime_d = merge(mtime_q, data_sram_wdata, data_sram_wen);
    end
    mti_d = (mtime_d >= mtcmp_d);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rdata_q <= '0;
      msip_q  <= 1'b0;
      mtime_q <= '0;
      mtcmp_q <= '1;
      presc_q <= '0;
      mti_q   <= 1'b0;
      bad_q   <= 1'b0;
    end else begin
      rdata_q <= rdata_d;
      msip_q  <= msip_d;
      mtime_q <= mtime_d;
      mtcmp_q <= mtcmp_d;
      presc_q <= presc_d;
      mti_q   <= mti_d;
      bad_q   <= bad_d;
    end
  end

  always_ff @(posedge clock) begin
    if (ram_wr) begin
      for (int i = 0; i < 8; i++) begin
        if (data_sram_wen[i])
          mem[ram_idx][8*i +: 8] <= data_sram_wdata[8*i +: 8];
      end
    end
  end

  assign data_sram_rdata = rdata_q;
  assign MSI             = msip_q;
  assign MTI             = mti_q;
  assign bad_access      = bad_q;

endmodule

// File: tb/tb_data_sram_responder.sv
// Bench for data_sram_responder: directed accesses with a queued
// scoreboard checking rdata/bad_access after each access edge.
module tb_data_sram_responder;

  logic        clock;
  logic        reset;
  logic        en;
  logic [7:0]  wen;
  logic [31:0] addr;
  logic [63:0] wdata;
  logic [63:0] rdata;
  logic        msi, mti, bad;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic        chk_rd;
    logic [63:0] rd;
    logic        bad;
    string       name;
  } exp_t;

  exp_t expq[$];

  data_sram_responder dut (
    .clock          (clock),
    .reset          (reset),
    .data_sram_en   (en),
    .data_sram_wen  (wen),
    .data_sram_addr (addr),
    .data_sram_wdata(wdata),
    .data_sram_rdata(rdata),
    .MSI            (msi),
    .MTI            (mti),
    .bad_access     (bad)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Monitor: every accepted access produces one scoreboard entry
  initial begin
    logic was_acc;
    exp_t e;
    forever begin
      @(posedge clock);
      was_acc = reset && en;
      #1;
      if (was_acc) begin
        if (expq.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL sb_empty: got 0 entries want 1");
        end else begin
          e = expq.pop_front();
          chk({e.name, "_bad"}, {63'd0, bad}, {63'd0, e.bad});
          if (e.chk_rd) chk({e.name, "_rd"}, rdata, e.rd);
        end
      end
    end
  end

  task automatic access(input logic [7:0] w, input logic [31:0] a,
                        input logic [63:0] d, input logic c,
                        input logic [63:0] er, input logic eb,
                        input string nm);
    exp_t e;
    @(negedge clock);
    en = 1'b1; wen = w; addr = a; wdata = d;
    e.chk_rd = c; e.rd = er; e.bad = eb; e.name = nm;
    expq.push_back(e);
  endtask

  task automatic wr(input logic [7:0] w, input logic [31:0] a,
                    input logic [63:0] d, input logic eb, input string nm);
    access(w, a, d, 1'b0, 64'd0, eb, nm);
  endtask

  task automatic rd(input logic [31:0] a, input logic [63:0] er,
                    input logic eb, input string nm);
    access(8'h00, a, 64'd0, 1'b1, er, eb, nm);
  endtask

  task automatic idle();
    @(negedge clock);
    en = 1'b0; wen = 8'h00;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; en = 1'b0; wen = 8'h00;
    addr = 32'h0; wdata = 64'h0;
    #3;
    chk("rst_rdata", rdata, 64'd0);
    chk("rst_msi", {63'd0, msi}, 64'd0);
    chk("rst_mti", {63'd0, mti}, 64'd0);
    chk("rst_bad", {63'd0, bad}, 64'd0);
    repeat (2) @(posedge clock);
    #2 reset = 1'b1;

    wr(8'hFF, 32'h8000_0000, 64'h0123_4567_89AB_CDEF, 1'b0, "t1_wr");
    rd(32'h8000_0000, 64'h0123_4567_89AB_CDEF, 1'b0, "t1_rd");
    idle();
    chk("t1_mti", {63'd0, mti}, 64'd0);
    chk("t1_msi", {63'd0, msi}, 64'd0);

    wr(8'hFF, 32'h8000_0010, 64'h1122_3344_5566_7788, 1'b0, "t2_wr");
    wr(8'h0F, 32'h8000_0014, 64'hAAAA_AAAA_BBBB_BBBB, 1'b0, "t2_wrp");
    rd(32'h8000_0010, 64'h1122_3344_BBBB_BBBB, 1'b0, "t2_rd");
    wr(8'hFF, 32'h8000_0020, 64'h5555_6666_7777_8888, 1'b0, "t2_wr2");
    idle();
    chk("t2_hold", rdata, 64'h1122_3344_BBBB_BBBB);
    wr(8'hFF, 32'h8007_FFF8, 64'hDEAD_BEEF_CAFE_F00D, 1'b0, "top_wr");
    rd(32'h8007_FFF8, 64'hDEAD_BEEF_CAFE_F00D, 1'b0, "top_rd");
    rd(32'h8008_0000, 64'd0, 1'b1, "past_ram");
    rd(32'h7FFF_FFF8, 64'd0, 1'b1, "below_ram");

    wr(8'hFF, 32'h0200_4000, 64'd105, 1'b0, "t3_cmp");
    wr(8'hFF, 32'h0200_BFF8, 64'd100, 1'b0, "t3_time");
    idle();
    chk("t3_mti0", {63'd0, mti}, 64'd0);
    for (int k = 1; k <= 5; k++) begin
      idle();
      chk($sformatf("t3_mti%0d", k), {63'd0, mti},
          (k == 5) ? 64'd1 : 64'd0);
    end
    wr(8'hFF, 32'h0200_4000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, "t3_clr");
    idle();
    chk("t3_mti_clr", {63'd0, mti}, 64'd0);
    wr(8'h01, 32'h0200_4000, 64'h0000_0000_0000_0005, 1'b0, "cmp_part");
    rd(32'h0200_4000, 64'hFFFF_FFFF_FFFF_FF05, 1'b0, "cmp_rd");
    rd(32'h0200_0008, 64'd0, 1'b0, "clint_hole");
    idle();
    chk("cmp_mti", {63'd0, mti}, 64'd0);

    wr(8'h01, 32'h0200_0000, 64'd1, 1'b0, "t4_set");
    idle();
    chk("t4_msi1", {63'd0, msi}, 64'd1);
    rd(32'h0200_0000, 64'd1, 1'b0, "t4_rd1");
    wr(8'hFF, 32'h0200_0000, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, "t4_clr");
    idle();
    chk("t4_msi0", {63'd0, msi}, 64'd0);
    wr(8'h02, 32'h0200_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, "t4_nobe");
    rd(32'h0200_0000, 64'd0, 1'b0, "t4_rd0");

    rd(32'h1000_0000, 64'd0, 1'b1, "t5_rd");
    idle();
    idle();
    chk("t5_pulse", {63'd0, bad}, 64'd0);
    wr(8'hFF, 32'h1000_0000, 64'h1234_5678_9ABC_DEF0, 1'b1, "t5_wr");
    idle();
    idle();
    chk("t5_pulse2", {63'd0, bad}, 64'd0);
    rd(32'h8000_0010, 64'h1122_3344_BBBB_BBBB, 1'b0, "t5_ram");
    rd(32'h0200_4000, 64'hFFFF_FFFF_FFFF_FF05, 1'b0, "t5_cmp");

    wr(8'hFF, 32'h0200_BFF8, 64'd500, 1'b0, "t6_time");
    wr(8'hFF, 32'h0200_4000, 64'd0, 1'b0, "t6_cmp");
    wr(8'h01, 32'h0200_0000, 64'd1, 1'b0, "t6_msip");
    rd(32'h0200_BFF8, 64'd502, 1'b0, "t6_rd");
    idle();
    chk("t6_pre_mti", {63'd0, mti}, 64'd1);
    chk("t6_pre_msi", {63'd0, msi}, 64'd1);
    @(negedge clock);
    en = 1'b1; wen = 8'hFF; addr = 32'h8000_0030; wdata = 64'h77;
    #2 reset = 1'b0;
    #1;
    en = 1'b0; wen = 8'h00;
    chk("t6_rdata", rdata, 64'd0);
    chk("t6_mti", {63'd0, mti}, 64'd0);
    chk("t6_msi", {63'd0, msi}, 64'd0);
    chk("t6_bad", {63'd0, bad}, 64'd0);
    repeat (2) @(posedge clock);
    #2 reset = 1'b1;
    rd(32'h0200_BFF8, 64'd0, 1'b0, "t6_time0");
    rd(32'h0200_BFF8, 64'd1, 1'b0, "t6_time1");
    rd(32'h0200_4000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, "t6_cmp1");
    idle();
    chk("t6_post_mti", {63'd0, mti}, 64'd0);

    repeat (3) idle();
    chk("sb_drain", 64'(expq.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
